// File: rtl/sar_search_if.sv
// Handshake and comparator bundle for sar_search.
// master = search engine side, slave = requester/comparator side.
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             cmp_gt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, cmp_eq, cmp_lt, cmp_gt,
    output trial, busy, done, result, found, err
  );

  modport slave (
    output start, cmp_eq, cmp_lt, cmp_gt,
    input  trial, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against an external comparator.
// Optional build macro SAR_EARLY_EXIT_EN: a sampled cmp_eq ends the search at once.
module sar_search #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sar_search_if.master bus
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_TRIAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic [2:0]       resp;
  logic             resp_ok;
  logic             early_hit;
  logic [WIDTH-1:0] bit_m;
  logic [WIDTH-1:0] code_clr;
  logic [WIDTH-1:0] code_upd;

  assign resp     = {bus.cmp_eq, bus.cmp_lt, bus.cmp_gt};
  assign resp_ok  = $onehot(resp);
  assign bit_m    = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
  assign code_clr = trial_q & ~bit_m;
  // eq keeps the bit just like lt: the trial is not above the target
  assign code_upd = (bus.cmp_eq || bus.cmp_lt) ? trial_q : code_clr;

`ifdef SAR_EARLY_EXIT_EN
  assign early_hit = bus.cmp_eq;
`else
  assign early_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          trial_d  = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d    = IW'(WIDTH-1);
          busy_d   = 1'b1;
          state_d  = S_TRIAL;
        end
      end
      S_TRIAL: begin
        if (!resp_ok) begin
          // broken comparator: keep only the bits already decided
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = code_clr;
          trial_d  = '0;
          idx_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          if (bus.cmp_eq) found_d = 1'b1;
          if (early_hit) begin
            result_d = trial_q;
            trial_d  = '0;
            idx_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else if (idx_q != '0) begin
            trial_d = code_upd | (bit_m >> 1);
            idx_d   = idx_q - 1'b1;
          end else begin
            result_d = code_upd;
            trial_d  = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        trial_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: behavioural comparator plus arithmetic model of the search.
// Honours SAR_EARLY_EXIT_EN when the build defines it.
module tb_sar_search;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_search_if #(.WIDTH(W)) bus ();
  sar_search #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;
  int tgt   = 0;
  int inj_s = 0;
  int cur_s = 0;

  // comparator against the hidden target, with an optional broken response
  always_comb begin
    if (inj_s != 0 && cur_s == inj_s) begin
      bus.cmp_eq = 1'b0;
      bus.cmp_lt = 1'b1;
      bus.cmp_gt = 1'b1;
    end else begin
      bus.cmp_eq = (int'(bus.trial) == tgt);
      bus.cmp_lt = (int'(bus.trial) <  tgt);
      bus.cmp_gt = (int'(bus.trial) >  tgt);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // number of samples before the search would naturally end
  function automatic int nat_len(input int t);
    int n;
    n = W;
`ifdef SAR_EARLY_EXIT_EN
    if (t != 0) begin
      for (int i = W - 1; i >= 0; i--) if (((t >> i) & 1) == 1) n = W - i;
    end
`endif
    return n;
  endfunction

  // binary search: top s-1 bits decided from the target, next bit tried
  function automatic int exp_trial(input int t, input int s);
    return ((t >> (W - s + 1)) << (W - s + 1)) | (1 << (W - s));
  endfunction

  task automatic search(input int t, input int inj, input bit skip_start,
                        input bit poke, input bit chain_next);
    int  lat, s, r_exp, f_exp;
    bit  e_exp, got;
    tgt   = t;
    inj_s = inj;
    lat   = nat_len(t);
    e_exp = 1'b0;
    if (inj != 0 && inj <= lat) begin
      lat   = inj;
      e_exp = 1'b1;
    end
    r_exp = e_exp ? ((t >> (W - inj + 1)) << (W - inj + 1)) : t;
    f_exp = (!e_exp && t != 0) ? 1 : 0;
    if (!skip_start) begin
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk("start_busy",   32'(bus.busy), 1);
    chk("start_clr_r",  32'(bus.result), 0);
    chk("start_clr_f",  32'(bus.found), 0);
    chk("start_clr_e",  32'(bus.err), 0);
    s = 0;
    got = 1'b0;
    while (!got && s < W + 4) begin
      s++;
      cur_s = s;
      if (s <= lat) chk($sformatf("trial_s%0d", s), 32'(bus.trial), exp_trial(t, s));
      if (poke && s == 2) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) got = 1'b1;
    end
    cur_s = 0;
    chk("done_seen", 32'(got), 1);
    chk("latency",   s, lat);
    chk("busy_low",  32'(bus.busy), 0);
    chk("result",    32'(bus.result), r_exp);
    chk("found",     32'(bus.found), f_exp);
    chk("err",       32'(bus.err), 32'(e_exp));
    chk("trial_0",   32'(bus.trial), 0);
    if (chain_next) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk("done_pulse", 32'(bus.done), 0);
      chk("res_held",   32'(bus.result), r_exp);
      chk("fnd_held",   32'(bus.found), f_exp);
      chk("busy_idle",  32'(bus.busy), 0);
    end
    inj_s = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    #12;
    chk("rst_trial",  32'(bus.trial), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_done",   32'(bus.done), 0);
    chk("rst_found",  32'(bus.found), 0);
    chk("rst_err",    32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corner targets
    search(100, 0, 0, 0, 0);
    search(0,   0, 0, 0, 0);
    search(255, 0, 0, 0, 0);
    search(128, 0, 0, 0, 0);
    search(96,  0, 0, 0, 0);
    search(1,   0, 0, 0, 0);
    // broken comparator at the third sample
    search(100, 3, 0, 0, 0);
    // start while busy is ignored
    search(100, 0, 0, 1, 0);
    // start held in the done cycle: back-to-back, clearing held err
    search(100, 3, 0, 0, 1);
    search(200, 0, 1, 0, 1);
    search(37,  0, 1, 0, 0);

    // asynchronous reset during sample 4
    tgt = 100;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_trial",  32'(bus.trial), 0);
    chk("arst_busy",   32'(bus.busy), 0);
    chk("arst_result", 32'(bus.result), 0);
    chk("arst_done",   32'(bus.done), 0);
    chk("arst_found",  32'(bus.found), 0);
    chk("arst_err",    32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst_nodone", 32'(bus.done), 0);
    end
    search(37, 0, 0, 0, 0);

    // randomized targets, occasionally with a broken response
    for (int i = 0; i < 24; i++) begin
      int t, inj;
      t   = int'($urandom_range(0, (1 << W) - 1));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      search(t, inj, 0, ($urandom_range(0, 1) == 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that drives a trial code into an external magnitude comparator and consumes its eq/lt/gt response. It sits on the initiator side of the comparator blocks. It binary-searches MSB-first for a hidden target value held on the comparator's other operand, and returns the matching or floor code. Typical users are threshold finders and ADC-style code searches.

## Interface
- `WIDTH`, default 8: width of the trial code and result; legal values 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a new search; honoured only when `busy`=0.
- `trial`  out  WIDTH  registered trial code presented to the comparator's `a` operand.
- `cmp_eq`  in  1  comparator response: `trial` == target.
- `cmp_lt`  in  1  comparator response: `trial` < target.
- `cmp_gt`  in  1  comparator response: `trial` > target.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle pulse when a search finishes.
- `result`  out  WIDTH  final code; held until the next accepted `start`.
- `found`  out  1  an exact match (`cmp_eq`) was sampled during the search; held.
- `err`  out  1  the comparator response was not one-hot; held.

## Operation
- States:
  - IDLE: `busy`=0.
  - TRIAL: `busy`=1.
- Internal bit index `idx` runs from WIDTH-1 down to 0.
- IDLE with `start`=1:
  - Clear `result`, `found` and `err`.
  - Set `trial` = 1<<(WIDTH-1) and `idx` = WIDTH-1.
  - Go to TRIAL.
- TRIAL: each edge samples {`cmp_eq`, `cmp_lt`, `cmp_gt`} against the current `trial`.
  - `cmp_lt`: keep bit `idx`.
  - `cmp_gt`: clear bit `idx`.
  - `cmp_eq`: set `found`=1 and keep bit `idx`. Early termination is governed by Configuration.
  - If `idx`>0: set bit `idx`-1 in `trial` and decrement `idx`.
  - If `idx`=0: `result` = updated code, `trial` returns to 0, pulse `done`, go to IDLE.
- Non-one-hot response (zero or multiple bits set) in TRIAL:
  - Abort immediately and set `err`=1 and `found`=0.
  - `result` = current `trial` with bit `idx` cleared.
  - Pulse `done` and go to IDLE.
- `start` is ignored while `busy`=1. No restart and no queueing.
- Result semantics: `result` = largest code ≤ target.
  - Target 0 gives `result`=0 and `found`=0, because 0 is never trialled.
  - Every other in-range target gives `found`=1.
- Arithmetic is unsigned with no wrap-around. `trial` never exceeds 2^WIDTH-1.

## Timing
- Reset values:
  - `trial`=0, `result`=0, `idx`=0.
  - `busy`=0, `done`=0, `found`=0, `err`=0.
  - State IDLE.
- The comparator path is combinational from `trial` to the `cmp_*` inputs and is sampled on the next edge. One trial per cycle.
- Start accepted at edge k: `busy` and the first `trial` are visible after edge k.
- Full-length search: the final sample is at edge k+WIDTH. After that edge `done`=1, `busy`=0 and `result` is valid, all in the same cycle.
- Early exit at sample i (1-based): `done` follows edge k+i.
- `done` is high for exactly one cycle. `result`, `found` and `err` stay stable from the `done` cycle until the next accepted `start`.
- `start` asserted in the `done` cycle is accepted, giving back-to-back searches with no idle gap.
- Asynchronous reset mid-search returns all state to reset values immediately. No `done` is issued for the aborted search.

## Configuration
- `SAR_EARLY_EXIT_EN` defined:
  - A sampled `cmp_eq` ends the search at once.
  - `result` = current `trial`, `found`=1, `done` pulses.
- Not defined:
  - The search always runs the full WIDTH samples.
  - `cmp_eq` sets the sticky `found` and is otherwise treated as `cmp_lt` (bit kept).
  - `result` is identical in both builds; only latency differs.

## Test plan
1. WIDTH=8, target 100, macro off: `trial` sequence 128,64,96,112,104,100,102,101. `done` 8 cycles after `busy` rises; `result`=100, `found`=1, `err`=0.
2. Target 0: `trial` sequence 128,64,…,1. `result`=0, `found`=0. Target 255: `result`=255, `found`=1.
3. Macro on, target 128: `done` one cycle after `busy` rises; `result`=128, `found`=1. Target 96: `done` after 3 samples with `result`=96.
4. Force `cmp_lt` and `cmp_gt` both high at the third sample with target 100: `err`=1, `found`=0, `result`=64, `done` after 3 samples.
5. `start` pulsed while busy is ignored, with `result` unchanged. `start` held through the `done` cycle begins a new search the next cycle and clears the held `found`/`err`.
6. Assert `rst_n`=0 during sample 4: all outputs go to 0 asynchronously. After release, a fresh `start` with target 37 yields `result`=37.
